// File: rtl/sda_tx.sv
// sda_tx -- single-wire serial frame transmitter.
//
// Each accepted request {in_addr, in_data} becomes one frame, sent one bit
// per clock:
//   PRE(1) START(0) CMD(1) ADDR[0..7] DATA[0..15] [PARITY] STOP(1)
// Address and data bits go out LSB first. One request can wait in a
// pending register while a frame is on the wire. A waiting request starts
// right after the STOP bit, with no gap cycle.
//
// Build option:
//   SDA_TX_PARITY_EN - when defined, a PARITY bit goes between DATA and STOP.
//                      It is the even parity (XOR) of the 24 address and
//                      data bits, so a frame takes 29 cycles instead of 28.
//
// Parameter:
//   IDLE_RELEASE - 1: sda_oe is low in IDLE. 0: the line is driven high in IDLE.
//
// Ports:
//   clk        - clock; all state changes on its rising edge
//   reset      - asynchronous active-high reset
//   in_valid   - frame request valid
//   in_ready   - request accepted on a rising edge where in_valid & in_ready
//   in_addr    - frame address (8 bits)
//   in_data    - frame data (16 bits)
//   sda_o      - serial data bit (registered)
//   sda_oe     - drive enable for sda_o (registered)
//   busy       - high whenever the FSM is not in IDLE
//   frame_done - one-cycle pulse during the STOP bit
module sda_tx #(
  parameter int IDLE_RELEASE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_addr,
  input  logic [15:0] in_data,
  output logic        sda_o,
  output logic        sda_oe,
  output logic        busy,
  output logic        frame_done
);

  localparam logic OE_IDLE = (IDLE_RELEASE == 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_START  = 3'd2,
    S_CMD    = 3'd3,
    S_ADDR   = 3'd4,
    S_DATA   = 3'd5,
`ifdef SDA_TX_PARITY_EN
    S_PARITY = 3'd6,
`endif
    S_STOP   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] shift_q, shift_d;      // {data, addr}; bit 0 is the bit being sent
  logic [23:0] pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic [4:0]  cnt_q, cnt_d;          // bits left in the current field, minus one
  logic        sda_o_q, sda_o_d;
  logic        sda_oe_q, sda_oe_d;
  logic        done_q, done_d;
`ifdef SDA_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        accept;
  logic        direct_load;
  logic [23:0] in_word;

  assign in_word  = {in_data, in_addr};
  // The reset term stops any request from being accepted while reset is high.
  assign in_ready = ~pend_full_q & ~reset;
  assign accept   = in_valid & in_ready;
  // Acceptance needs pending to be empty, so in STOP the new word can go
  // straight into the shift register.
  assign direct_load = accept & ((state_q == S_IDLE) | (state_q == S_STOP));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
`ifdef SDA_TX_PARITY_EN
    par_d       = par_q;
`endif

    if (accept && !direct_load) begin
      pend_d      = in_word;
      pend_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (direct_load) begin
          state_d = S_PRE;
          shift_d = in_word;
`ifdef SDA_TX_PARITY_EN
          par_d   = ^in_word;
`endif
        end
      end
      S_PRE:   state_d = S_START;
      S_START: state_d = S_CMD;
      S_CMD: begin
        state_d = S_ADDR;
        cnt_d   = 5'd7;
      end
      S_ADDR: begin
        shift_d = {1'b0, shift_q[23:1]};
        if (cnt_q == 5'd0) begin
          state_d = S_DATA;
          cnt_d   = 5'd15;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DATA: begin
        shift_d = {1'b0, shift_q[23:1]};
        if (cnt_q == 5'd0) begin
`ifdef SDA_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
`ifdef SDA_TX_PARITY_EN
      S_PARITY: state_d = S_STOP;
`endif
      S_STOP: begin
        if (pend_full_q) begin
          state_d     = S_PRE;
          shift_d     = pend_q;
          pend_full_d = 1'b0;
`ifdef SDA_TX_PARITY_EN
          par_d       = ^pend_q;
`endif
        end else if (direct_load) begin
          state_d = S_PRE;
          shift_d = in_word;
`ifdef SDA_TX_PARITY_EN
          par_d   = ^in_word;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line outputs are registered. They are taken from the next state,
    // so they show the bit of the state just entered.
    case (state_d)
      S_START: sda_o_d = 1'b0;
      S_ADDR,
      S_DATA:  sda_o_d = shift_d[0];
`ifdef SDA_TX_PARITY_EN
      S_PARITY: sda_o_d = par_d;
`endif
      default: sda_o_d = 1'b1;
    endcase
    sda_oe_d = (state_d != S_IDLE) | OE_IDLE;
    done_d   = (state_d == S_STOP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      sda_o_q     <= 1'b1;
      sda_oe_q    <= OE_IDLE;
      done_q      <= 1'b0;
`ifdef SDA_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      cnt_q       <= cnt_d;
      sda_o_q     <= sda_o_d;
      sda_oe_q    <= sda_oe_d;
      done_q      <= done_d;
`ifdef SDA_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign sda_o      = sda_o_q;
  assign sda_oe     = sda_oe_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_sda_tx.sv
// tb_sda_tx -- self-checking bench for sda_tx.
// Runs one instance with IDLE_RELEASE=1 and one with IDLE_RELEASE=0 on the
// same stimulus. A queue holds the expected {sda_o, sda_oe, busy, frame_done}
// value for each cycle. It is filled when a request is driven and emptied one
// entry per cycle at the falling edge.
module tb_sda_tx;

`ifdef SDA_TX_PARITY_EN
  localparam int FLEN = 29;
`else
  localparam int FLEN = 28;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_addr;
  logic [15:0] in_data;
  logic        in_ready, sda_o, sda_oe, busy, frame_done;
  logic        in_ready0, sda_o0, sda_oe0, busy0, frame_done0;

  always #5 clk = ~clk;

  sda_tx #(.IDLE_RELEASE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .sda_o(sda_o), .sda_oe(sda_oe),
    .busy(busy), .frame_done(frame_done)
  );

  sda_tx #(.IDLE_RELEASE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_addr(in_addr), .in_data(in_data), .sda_o(sda_o0), .sda_oe(sda_oe0),
    .busy(busy0), .frame_done(frame_done0)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        par;   // even parity of addr and data, worked out by hand
  } vec_t;

  vec_t       vecs [6];
  logic [3:0] exp_q [$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [15:0] d, input logic p);
    exp_q.push_back(4'b1110);                                 // PRE
    exp_q.push_back(4'b0110);                                 // START
    exp_q.push_back(4'b1110);                                 // CMD
    for (int i = 0; i < 8; i++)  exp_q.push_back({a[i], 3'b110});
    for (int i = 0; i < 16; i++) exp_q.push_back({d[i], 3'b110});
`ifdef SDA_TX_PARITY_EN
    exp_q.push_back({p, 3'b110});                             // PARITY
`endif
    exp_q.push_back(4'b1111);                                 // STOP + frame_done
  endtask

  // Drive a request and queue its expected frame, starting at the next cycle.
  task automatic send(input logic [7:0] a, input logic [15:0] d, input logic p);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    push_frame(a, d, p);
    $display("[TB] request addr=%02h data=%04h parity=%0d", a, d, p);
  endtask

  // One cycle: at the falling edge, compare both instances with the next
  // expected value. When nothing is expected, the line must be idle.
  task automatic tick();
    logic [3:0] e;
    logic [3:0] e0;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 4'b1000;
    e0 = {e[3], (e[1] ? e[2] : 1'b1), e[1], e[0]};
    check("line_rel1", {28'd0, sda_o, sda_oe, busy, frame_done}, {28'd0, e});
    check("line_rel0", {28'd0, sda_o0, sda_oe0, busy0, frame_done0}, {28'd0, e0});
  endtask

  initial begin
    vecs[0] = '{8'h05, 16'hA5C3, 1'b0};
    vecs[1] = '{8'h1F, 16'hFFFF, 1'b1};
    vecs[2] = '{8'h00, 16'h0000, 1'b0};
    vecs[3] = '{8'h01, 16'h0000, 1'b1};
    vecs[4] = '{8'h03, 16'h0000, 1'b0};
    vecs[5] = '{8'hAA, 16'h5555, 1'b0};

    // Reset, with a request held valid that must not be taken.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 8'h5A;
    in_data  = 16'h1234;
    repeat (3) tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);
    check("idle_no_frame", exp_q.size(), 0);

    // Single frames from IDLE. Inputs change randomly after acceptance.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].addr, vecs[v].data, vecs[v].par);
      tick();
      in_valid = 1'b0;
      for (int i = 1; i < FLEN; i++) begin
        in_addr = 8'($urandom);
        in_data = 16'($urandom);
        tick();
      end
      tick();
      tick();
    end

    // Back-to-back: the second request waits in pending during frame 1.
    send(8'h05, 16'hA5C3, 1'b0);
    tick();                                     // frame A PRE
    in_addr = 8'h1F;
    in_data = 16'hFFFF;
    push_frame(8'h1F, 16'hFFFF, 1'b1);
    $display("[TB] request addr=1f data=ffff parity=1 (held during frame)");
    tick();                                     // frame A START, pending now full
    check("b2b_ready_low", {31'd0, in_ready}, 32'd0);
    check("b2b_ready_low_r0", {31'd0, in_ready0}, 32'd0);
    in_valid = 1'b0;
    for (int i = 3; i <= FLEN; i++) begin
      tick();
      check("b2b_ready_hold", {31'd0, in_ready}, 32'd0);
    end
    tick();                                     // frame B PRE, no gap cycle
    check("b2b_ready_rise", {31'd0, in_ready}, 32'd1);
    for (int i = 2; i <= FLEN; i++) tick();
    tick();

    // Request shown during STOP with pending empty.
    send(8'hAA, 16'h5555, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 2; i <= FLEN; i++) tick();     // last tick shows STOP
    send(8'h00, 16'h0000, 1'b0);
    tick();                                     // must already be PRE
    in_valid = 1'b0;
    check("stop_accept_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 2; i <= FLEN; i++) tick();
    tick();

    // Reset in the middle of DATA (the cycle that shows data bit 7).
    send(8'h05, 16'hA5C3, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 2; i <= 19; i++) tick();
    reset = 1'b1;
    #1;
    check("async_reset_rel1", {28'd0, sda_o, sda_oe, busy, frame_done}, 32'h8);
    check("async_reset_rel0", {28'd0, sda_o0, sda_oe0, busy0, frame_done0}, 32'hC);
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("ready_after_abort", {31'd0, in_ready}, 32'd1);
    send(8'h1F, 16'hFFFF, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 2; i <= FLEN; i++) tick();
    tick();
    tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sda_tx.md
SDA_TX -- requirements
Module: sda_tx

Interface
REQ-001 SHALL have parameter IDLE_RELEASE, default 1; 1 = release sda_oe in IDLE, 0 = drive sda_o=1 with sda_oe=1 in IDLE.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, frame request valid.
REQ-005 SHALL have port in_ready, output, 1, request accepted on any posedge with in_valid&in_ready.
REQ-006 SHALL have port in_addr, input, 8, frame address.
REQ-007 SHALL have port in_data, input, 16, frame data.
REQ-008 SHALL have port sda_o, output, 1, serial data bit, registered.
REQ-009 SHALL have port sda_oe, output, 1, SDA drive enable, registered; line pulled up externally when low.
REQ-010 SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse coincident with the STOP bit.

Function
REQ-012 SHALL implement states IDLE, PRE, START, CMD, ADDR, DATA, STOP (plus PARITY, see REQ-026), one bit per clk cycle.
REQ-013 SHALL drive per state: PRE sda_o=1; START sda_o=0; CMD sda_o=1; ADDR in_addr[0..7] LSB first, 8 cycles; DATA in_data[0..15] LSB first, 16 cycles; STOP sda_o=1; sda_oe=1 in all non-IDLE states.
REQ-014 SHALL, on acceptance at edge k from IDLE, show PRE after edge k, START after k+1, CMD after k+2, addr[0] after k+3, data[0] after k+11, STOP after k+27 (28-cycle frame).
REQ-015 SHALL hold an active shift register plus one pending holding register; in_ready = !pending_full.
REQ-016 SHALL load an accepted request directly into the shift register when state is IDLE, or state is STOP with pending empty; otherwise into pending.
REQ-017 SHALL, at end of STOP, go to PRE if a word is queued (pending or same-cycle direct load), else IDLE; back-to-back frames have no gap cycle.
REQ-018 SHALL clear pending_full when its word moves to the shift register; in_ready rises the following cycle.
REQ-019 SHALL use a 5-bit bit counter for ADDR/DATA, reloaded on each state entry, no wrap beyond field length.
REQ-020 SHALL ignore in_addr/in_data changes after acceptance (captured values only).
REQ-021 SHALL keep frame_done low except exactly one cycle per frame.

Reset
REQ-022 SHALL, on reset assertion, immediately (asynchronously) force state IDLE, sda_o=1, sda_oe=(IDLE_RELEASE?0:1), busy=0, frame_done=0, pending cleared.
REQ-023 SHALL abort an in-progress frame on reset with no partial STOP; in_ready=1 from the first edge after deassertion.
REQ-024 SHALL not accept a request while reset is high.

Configuration
REQ-025 SHALL support macro SDA_TX_PARITY_EN.
REQ-026 SHALL, with SDA_TX_PARITY_EN defined, insert state PARITY between DATA and STOP driving even parity (XOR of 8 addr + 16 data bits), frame 29 cycles, STOP after k+28.
REQ-027 SHALL, without SDA_TX_PARITY_EN, omit PARITY entirely; frame 28 cycles per REQ-014.

Verification
REQ-028 Single frame: addr=0x05, data=0xA5C3 from IDLE -> sda_o sequence 1,0,1,1,0,1,0,0,0,0,0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1; frame_done once at cycle 28.
REQ-029 Back-to-back: second request (0x1F,0xFFFF) held valid during frame 1 -> accepted into pending, in_ready low until transfer, frame 2 PRE immediately after frame 1 STOP.
REQ-030 Accept in STOP: pending empty, request (0x00,0x0000) presented in STOP cycle -> PRE next cycle, addr/data bits all 0.
REQ-031 Reset mid-DATA: assert reset at data bit 7 -> sda_oe/sda_o/busy at reset values without waiting for clk; next request after release starts clean frame.
REQ-032 Parity build: SDA_TX_PARITY_EN, addr=0x01, data=0x0000 -> parity bit 1 before STOP; addr=0x03 -> parity bit 0; frame_done at cycle 29.
REQ-033 IDLE_RELEASE=0: idle -> sda_oe=1, sda_o=1 continuously; frame bits unchanged.
